// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, format codes and the decoded-instruction record.
// Imported by the decode stage and by the immediate generator.
package rv_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  // Every RV32I immediate fits in 32 bits; widening to XLEN happens at the output.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } dec_t;

  // All valid opcodes end in 2'b11, so a bad low pair also falls into the default.
  function automatic fmt_e classify(input logic [31:0] instr);
    fmt_e f;
    case (instr[6:0])
      OP_R:                                          f = FMT_R;
      OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: f = FMT_I;
      OP_STORE:                                      f = FMT_S;
      OP_BRANCH:                                     f = FMT_B;
      OP_LUI, OP_AUIPC:                              f = FMT_U;
      OP_JAL:                                        f = FMT_J;
      default:                                       f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv_decode_stage_imm_gen.sv
// Combinational immediate generator: instruction word plus format code to a
// sign-extended XLEN immediate. Illegal and R-type produce zero.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a main register M and a skid register S,
// giving a registered in_ready and full one-per-cycle throughput.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_W        = 32,
  parameter int ZERO_UNUSED = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  // Handshake: a transfer happens on a port when valid && ready are both high in
  // the same cycle; out_* data holds steady while out_valid && !out_ready.

  fmt_e            fmt;
  logic [XLEN-1:0] imm_x;
  dec_t            dec;
  dec_t            m_q, s_q;
  logic [PC_W-1:0] m_pc, s_pc;
  logic            m_valid, s_valid, in_ready_q;
  logic            in_fire, m_free;

  assign fmt = classify(in_instr);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm_x)
  );

  always_comb begin
    dec         = '0;
    dec.opcode  = in_instr[6:0];
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.funct3  = in_instr[14:12];
    dec.funct7  = in_instr[31:25];
    dec.imm     = imm_x[31:0];
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_ILL);
    if (ZERO_UNUSED != 0) begin
      if (fmt == FMT_S || fmt == FMT_B) dec.rd = '0;
      if (fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) dec.rs2 = '0;
      if (fmt == FMT_U || fmt == FMT_J) begin
        dec.rs1    = '0;
        dec.funct3 = '0;
      end
      // Shift-immediates carry their arithmetic/logical select in funct7.
      if (fmt != FMT_R && !(in_instr[6:0] == OP_IMM && in_instr[13:12] == 2'b01))
        dec.funct7 = '0;
    end
    if (fmt == FMT_ILL) begin
      dec.rd  = '0;
      dec.rs1 = '0;
      dec.rs2 = '0;
    end
  end

  assign in_fire = in_valid && in_ready_q;
  assign m_free  = !m_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
      m_pc       <= '0;
      s_pc       <= '0;
    end else if (flush) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (m_free) begin
      // S is older than anything on the input, and in_ready is low while S is full.
      if (s_valid) begin
        m_q        <= s_q;
        m_pc       <= s_pc;
        m_valid    <= 1'b1;
        s_valid    <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (in_fire) begin
        m_q     <= dec;
        m_pc    <= in_pc;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      s_q        <= dec;
      s_pc       <= in_pc;
      s_valid    <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = m_valid;
  assign out_pc      = m_pc;
  assign out_opcode  = m_q.opcode;
  assign out_rd      = m_q.rd;
  assign out_rs1     = m_q.rs1;
  assign out_rs2     = m_q.rs2;
  assign out_funct3  = m_q.funct3;
  assign out_funct7  = m_q.funct7;
  assign out_imm     = XLEN'($signed(m_q.imm));
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed decode cases, stall/flush/reset scenarios
// and a randomized phase scored against an arithmetic reference model.
module tb_rv_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  logic        hold_pending = 1'b0;
  logic [31:0] hold_pc, hold_imm;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  rv_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA rules, immediates built as signed integers.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t   e;
    int     f;
    longint v;
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'h33:                             f = 0;
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: f = 1;
      7'h23:                             f = 2;
      7'h63:                             f = 3;
      7'h37, 7'h17:                      f = 4;
      7'h6F:                             f = 5;
      default:                           f = 6;
    endcase
    v = 0;
    case (f)
      1: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
      2: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (v >= 2048) v -= 4096; end
      3: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
            longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      4: begin v = longint'(ins[31:12]) * 4096; if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000; end
      5: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
            longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    e         = '0;
    e.pc      = pc;
    e.opcode  = op;
    e.fmt     = 3'(f);
    e.illegal = (f == 6);
    e.imm     = v[31:0];
    e.rd      = (f == 2 || f == 3 || f == 6) ? 5'd0 : ins[11:7];
    e.rs1     = (f == 4 || f == 5 || f == 6) ? 5'd0 : ins[19:15];
    e.rs2     = (f == 0 || f == 2 || f == 3) ? ins[24:20] : 5'd0;
    e.f3      = (f == 4 || f == 5) ? 3'd0 : ins[14:12];
    e.f7      = (f == 0 || (op == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)))
                ? ins[31:25] : 7'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
                              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 12);
    if (k < 11) r[6:0] = ops[k];
    return r;
  endfunction

  // One clock: score at the falling edge, then step to just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    check("occ_out_valid", out_valid, exp_q.size() != 0);
    check("occ_in_ready", in_ready, exp_q.size() < 2);
    if (hold_pending) begin
      check("hold_pc", out_pc, hold_pc);
      check("hold_imm", out_imm, hold_imm);
    end
    if (!rst && out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pc", out_pc, e.pc);
      check("opcode", out_opcode, e.opcode);
      check("rd", out_rd, e.rd);
      check("rs1", out_rs1, e.rs1);
      check("rs2", out_rs2, e.rs2);
      check("imm", out_imm, e.imm);
      check("fmt", out_fmt, e.fmt);
      check("illegal", out_illegal, e.illegal);
      if (!e.illegal) begin
        check("funct3", out_funct3, e.f3);
        check("funct7", out_funct7, e.f7);
      end
    end
    if (rst || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
    hold_pending = out_valid && !out_ready && !rst && !flush;
    hold_pc      = out_pc;
    hold_imm     = out_imm;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_ctr;
    pc_ctr   = pc_ctr + 4;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      cycle();
    end
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_imm", out_imm, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_opcode", out_opcode, 7'h0);
    check("rst_illegal", out_illegal, 1'b0);
    rst = 1'b0;

    // addi x1,x2,-1
    out_ready = 1'b1;
    send(32'hFFF10093);
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1'b1);
    check("addi_fmt", out_fmt, 3'd1);
    check("addi_rd", out_rd, 5'd1);
    check("addi_rs1", out_rs1, 5'd2);
    check("addi_rs2", out_rs2, 5'd0);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    cycle();

    // sw then beq back-to-back, no bubble
    send(32'h00532423);
    check("sw_rs1", out_rs1, 5'd6);
    check("sw_rs2", out_rs2, 5'd5);
    check("sw_rd", out_rd, 5'd0);
    check("sw_imm", out_imm, 32'h00000008);
    send(32'hFE000EE3);
    in_valid = 1'b0;
    check("beq_valid", out_valid, 1'b1);
    check("beq_fmt", out_fmt, 3'd3);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    cycle();

    // jal and lui
    send(32'h001000EF);
    check("jal_imm", out_imm, 32'h00000800);
    check("jal_rd", out_rd, 5'd1);
    send(32'h123451B7);
    in_valid = 1'b0;
    check("lui_imm", out_imm, 32'h12345000);
    check("lui_rs1", out_rs1, 5'd0);
    cycle();

    // illegal word followed by a normal instruction
    send(32'h0000007F);
    check("ill_flag", out_illegal, 1'b1);
    check("ill_fmt", out_fmt, 3'd6);
    check("ill_imm", out_imm, 32'h0);
    send(32'hFFF10093);
    in_valid = 1'b0;
    check("after_ill_flag", out_illegal, 1'b0);
    check("after_ill_fmt", out_fmt, 3'd1);
    cycle();

    // five instructions against a 3-cycle downstream stall
    out_ready = 1'b0;
    send(32'h00100093);
    send(32'h00200113);
    check("stall_in_ready", in_ready, 1'b0);
    in_instr = 32'h00300193;
    in_pc    = pc_ctr;
    cycle();
    check("stall_in_ready_held", in_ready, 1'b0);
    out_ready = 1'b1;
    pc_ctr    = pc_ctr - 4;
    send(32'h00300193);
    send(32'h00400213);
    send(32'h00500293);
    drain();

    // flush with M and S full, input presented
    out_ready = 1'b0;
    send(32'h00A00513);
    send(32'h00B00593);
    in_instr = 32'h00C00613;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    drain();

    // flush with only M full and an acceptable input
    out_ready = 1'b0;
    send(32'h00D00693);
    in_instr = 32'h00E00713;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush2_out_valid", out_valid, 1'b0);
    drain();

    // reset mid-stream
    out_ready = 1'b0;
    send(32'hFFF10093);
    send(32'h001000EF);
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_imm", out_imm, 32'h0);
    check("mrst_pc", out_pc, 32'h0);
    check("mrst_rd", out_rd, 5'd0);
    check("mrst_opcode", out_opcode, 7'h0);
    drain();

    // randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = pc_ctr;
      pc_ctr    = pc_ctr + 4;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
